gmii_speed_detect: RTL and testbench
====================================

# gmii_speed_detect

Parametrised GMII/MII link-speed detector running on CLK200M. It measures the frequency of the PHY receive clock over a programmable window and classifies it as 1000M, 100M, 10M or no clock. A new classification reaches the outputs only after a programmable number of consecutive agreeing windows. A force mode lets software override the result. It drives the TX-clock mux select and the MAC GMII_1000M input, and replaces the fixed 200 ns single-shot RX-clock count.

## Interface
Parameters:
- WINDOW_CYCLES, 2000: CLK200M cycles per measurement window (10 us); must be ≥ 2.
- CNT_W, 12: RX edge-counter and MEAS_CNT width; 2^CNT_W must exceed the 125 MHz count per window.
- TH_GIG, 750: count ≥ TH_GIG classifies as 1000M.
- TH_FAST, 100: count ≥ TH_FAST classifies as 100M.
- TH_SLOW, 10: count ≥ TH_SLOW classifies as 10M; below this is no clock.
- STABLE_WINDOWS, 3: consecutive agreeing windows required before outputs update (1..15).

Ports:
- CLK200M  in  1  system clock, 200 MHz.
- SYS_RST  in  1  reset; asynchronous, active-high. Clock is CLK200M.
- GMII_RX_CLK  in  1  PHY RX clock, 2.5/25/125 MHz or stopped.
- FORCE_EN  in  1  level; override detected speed (CLK200M domain).
- FORCE_SPEED  in  2  forced code: 00 = 10M, 01 = 100M, 10 = 1000M; 11 is treated as 10M.
- SPEED  out  2  current speed code.
- CLK_OK  out  1  RX clock present (class ≠ none).
- GMII_1000M  out  1  1 when SPEED = 10 and (CLK_OK or FORCE_EN).
- SPEED_CHG  out  1  one-cycle pulse when SPEED, CLK_OK or GMII_1000M changes.
- MEAS_VALID  out  1  one-cycle pulse per completed window.
- MEAS_CNT  out  CNT_W  RX_CLK rising edges in the last window.

## Operation
- RX domain:
  - Free-running CNT_W binary counter incremented on every GMII_RX_CLK rising edge, registered as Gray code.
  - SYS_RST asserts asynchronously into this domain; deassertion passes through a 2-FF synchroniser clocked by GMII_RX_CLK.
- Crossing: the Gray value passes a 2-FF synchroniser on CLK200M, then converts to binary. Single-bit Gray change is guaranteed because f_RX < f_CLK200M.
- Window counter runs 0..WINDOW_CYCLES-1 and wraps. At terminal count:
  - delta = sampled_bin − prev_bin (mod 2^CNT_W); prev_bin ← sampled_bin.
  - Wrap-around of the RX counter is handled by the modulo subtraction.
- The first window after reset only loads prev_bin. It produces no MEAS_VALID and no classification.
- Classification, in priority order:
  - delta ≥ TH_GIG → 1000M.
  - delta ≥ TH_FAST → 100M.
  - delta ≥ TH_SLOW → 10M.
  - otherwise → none.
- Debounce:
  - A candidate register and a 4-bit stable counter.
  - Class equal to candidate: counter increments, saturating at STABLE_WINDOWS.
  - Class differs: candidate ← class, counter ← 1.
  - Counter reaching STABLE_WINDOWS with candidate differing from the committed state commits it: class none sets CLK_OK = 0 with SPEED held; otherwise SPEED ← class and CLK_OK = 1.
- Force:
  - While FORCE_EN = 1, SPEED = FORCE_SPEED (11 → 00). Measurement and debounce continue, but nothing commits.
  - CLK_OK continues to reflect the committed measurement.
  - On the FORCE_EN falling edge, the stable counter clears. SPEED holds the forced value until STABLE_WINDOWS agreeing windows commit the measured class.
- Reset values: SPEED = 00, CLK_OK = 0, GMII_1000M = 0, SPEED_CHG = 0, MEAS_VALID = 0, MEAS_CNT = 0. Internal state is cleared: window counter 0, stable counter 0, candidate = none, first-window flag set.
- Reset mid-window aborts the window. The next result is again the discard window.

## Timing
- T = window terminal cycle; delta is captured at T.
- T+1: MEAS_VALID = 1, MEAS_CNT = delta, and candidate/counter update.
- T+2: committed outputs change and SPEED_CHG pulses (exactly 1 cycle).
- FORCE_EN edge → SPEED/GMII_1000M change 1 cycle later, with a SPEED_CHG pulse if the value changes.
- A FORCE_EN edge coinciding with a commit cycle: force wins, and only one SPEED_CHG pulse is generated.
- Worst-case detection latency after a clock change: (STABLE_WINDOWS+1)·WINDOW_CYCLES + 4 cycles.
- Count tolerance: ±2 per window, from synchroniser and phase.

## Test plan
- 125 MHz RX_CLK from reset:
  - The first window produces no MEAS_VALID.
  - MEAS_CNT = 1250±2 on each later window.
  - GMII_1000M = 1, SPEED = 10 and CLK_OK = 1 at the 4th window +2 cycles, with one SPEED_CHG pulse.
- Switch 125 → 25 MHz:
  - MEAS_CNT = 250±2.
  - SPEED = 01 and GMII_1000M = 0 exactly after 3 agreeing windows, with a single SPEED_CHG.
- Stop RX_CLK at 2.5 MHz:
  - MEAS_CNT = 0.
  - CLK_OK falls after 3 windows with SPEED held at 00.
  - Restart at 2.5 MHz → CLK_OK = 1.
- Alternate 125/25 MHz every window: SPEED never changes and SPEED_CHG is never asserted.
- Force:
  - FORCE_EN = 1 with FORCE_SPEED = 10 while the link is at 25 MHz → GMII_1000M = 1 one cycle later.
  - Release → SPEED returns to 01 after 3 windows.
- Reset mid-window at 125 MHz → all outputs 0 immediately. RX counter near wrap (preload 4090) still gives MEAS_CNT = 1250±2.

Source files
------------

// File: rtl/gmii_speed_detect.sv
// GMII/MII link-speed detector: counts PHY RX clock edges over a CLK200M window,
// debounces the resulting class and drives the TX clock mux select / MAC speed.
module gmii_speed_detect #(
  parameter int WINDOW_CYCLES  = 2000,
  parameter int CNT_W          = 12,
  parameter int TH_GIG         = 750,
  parameter int TH_FAST        = 100,
  parameter int TH_SLOW        = 10,
  parameter int STABLE_WINDOWS = 3
) (
  input  logic             CLK200M,
  input  logic             SYS_RST,
  input  logic             GMII_RX_CLK,
  input  logic             FORCE_EN,
  input  logic [1:0]       FORCE_SPEED,
  output logic [1:0]       SPEED,
  output logic             CLK_OK,
  output logic             GMII_1000M,
  output logic             SPEED_CHG,
  output logic             MEAS_VALID,
  output logic [CNT_W-1:0] MEAS_CNT
);

  localparam int WIN_W = $clog2(WINDOW_CYCLES);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] TH_G = CNT_W'(TH_GIG);
  localparam logic [CNT_W-1:0] TH_F = CNT_W'(TH_FAST);
  localparam logic [CNT_W-1:0] TH_S = CNT_W'(TH_SLOW);
  localparam logic [3:0] STABLE_N = 4'(STABLE_WINDOWS);

  // Class codes double as SPEED codes; NONE uses the otherwise unused 11.
  typedef enum logic [1:0] {
    CLS_10   = 2'b00,
    CLS_100  = 2'b01,
    CLS_1000 = 2'b10,
    CLS_NONE = 2'b11
  } cls_t;

  typedef enum logic {
    ST_DISCARD,
    ST_RUN
  } state_t;

  logic [1:0]       rx_rst_pipe;
  logic             rx_rst;
  logic [CNT_W-1:0] rx_bin;
  logic [CNT_W-1:0] rx_bin_nxt;
  logic [CNT_W-1:0] rx_gray;
  logic [CNT_W-1:0] gray_s1;
  logic [CNT_W-1:0] gray_s2;
  logic [CNT_W-1:0] sync_bin;
  logic [CNT_W-1:0] prev_bin;
  logic [CNT_W-1:0] delta;
  logic [WIN_W-1:0] win_cnt;
  logic             win_end;
  state_t           state;
  cls_t             cls;
  cls_t             cand;
  logic [3:0]       stab;
  logic             force_d;
  logic             force_fall;
  logic             differs;
  logic             commit;
  logic [1:0]       speed_nxt;
  logic             ok_nxt;
  logic             gmii_nxt;

  // Reset enters the RX domain asynchronously but leaves it on an RX edge.
  always_ff @(posedge GMII_RX_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      rx_rst_pipe <= 2'b11;
    end else begin
      rx_rst_pipe <= {rx_rst_pipe[0], 1'b0};
    end
  end

  assign rx_rst     = rx_rst_pipe[1];
  assign rx_bin_nxt = rx_bin + CNT_W'(1);

  always_ff @(posedge GMII_RX_CLK or posedge rx_rst) begin
    if (rx_rst) begin
      rx_bin  <= '0;
      rx_gray <= '0;
    end else begin
      rx_bin  <= rx_bin_nxt;
      rx_gray <= rx_bin_nxt ^ (rx_bin_nxt >> 1);
    end
  end

  // Gray code changes one bit per RX edge, so a plain 2-FF sync is safe.
  always_ff @(posedge CLK200M or posedge SYS_RST) begin
    if (SYS_RST) begin
      gray_s1 <= '0;
      gray_s2 <= '0;
    end else begin
      gray_s1 <= rx_gray;
      gray_s2 <= gray_s1;
    end
  end

  always_comb begin
    sync_bin = '0;
    for (int i = 0; i < CNT_W; i++) begin
      sync_bin[i] = ^(gray_s2 >> i);
    end
  end

  assign delta      = sync_bin - prev_bin;
  assign win_end    = (win_cnt == WIN_LAST);
  assign force_fall = force_d & ~FORCE_EN;

  always_comb begin
    if (delta >= TH_G) begin
      cls = CLS_1000;
    end else if (delta >= TH_F) begin
      cls = CLS_100;
    end else if (delta >= TH_S) begin
      cls = CLS_10;
    end else begin
      cls = CLS_NONE;
    end
  end

  always_ff @(posedge CLK200M or posedge SYS_RST) begin
    if (SYS_RST) begin
      state      <= ST_DISCARD;
      win_cnt    <= '0;
      prev_bin   <= '0;
      MEAS_VALID <= 1'b0;
      MEAS_CNT   <= '0;
      cand       <= CLS_NONE;
      stab       <= '0;
      force_d    <= 1'b0;
    end else begin
      MEAS_VALID <= 1'b0;
      force_d    <= FORCE_EN;
      if (win_end) begin
        win_cnt  <= '0;
        prev_bin <= sync_bin;
        case (state)
          ST_DISCARD: state <= ST_RUN;
          ST_RUN: begin
            MEAS_VALID <= 1'b1;
            MEAS_CNT   <= delta;
            if (cls == cand) begin
              stab <= (stab >= STABLE_N) ? STABLE_N : stab + 4'd1;
            end else begin
              cand <= cls;
              stab <= 4'd1;
            end
          end
          default: state <= ST_DISCARD;
        endcase
      end else begin
        win_cnt <= win_cnt + WIN_W'(1);
      end
      // Leaving force mode restarts the agreement count from scratch.
      if (force_fall) begin
        stab <= '0;
      end
    end
  end

  always_comb begin
    speed_nxt = SPEED;
    ok_nxt    = CLK_OK;
    differs   = (cand == CLS_NONE) ? CLK_OK : (!CLK_OK || (SPEED != cand));
    commit    = MEAS_VALID && (stab == STABLE_N) && differs && !FORCE_EN && !force_fall;
    if (FORCE_EN) begin
      speed_nxt = (FORCE_SPEED == 2'b11) ? 2'b00 : FORCE_SPEED;
    end else if (commit) begin
      if (cand == CLS_NONE) begin
        ok_nxt = 1'b0;
      end else begin
        speed_nxt = cand;
        ok_nxt    = 1'b1;
      end
    end
    gmii_nxt = (speed_nxt == 2'b10) && (ok_nxt || FORCE_EN);
  end

  always_ff @(posedge CLK200M or posedge SYS_RST) begin
    if (SYS_RST) begin
      SPEED      <= 2'b00;
      CLK_OK     <= 1'b0;
      GMII_1000M <= 1'b0;
      SPEED_CHG  <= 1'b0;
    end else begin
      SPEED      <= speed_nxt;
      CLK_OK     <= ok_nxt;
      GMII_1000M <= gmii_nxt;
      SPEED_CHG  <= (speed_nxt != SPEED) || (ok_nxt != CLK_OK) || (gmii_nxt != GMII_1000M);
    end
  end

endmodule

// File: tb/tb_gmii_speed_detect.sv
// Scoreboard bench for gmii_speed_detect: stimulus queues expected window counts
// and output changes with their exact cycle; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_gmii_speed_detect;

  localparam int WIN = 2000;

  typedef struct {
    int exp_cyc;
    int nom;
    int tol;
  } meas_exp_t;

  typedef struct {
    int         exp_cyc;
    logic [1:0] spd;
    logic       ok;
    logic       gig;
  } chg_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_clk = 1'b0;
  logic        force_en = 1'b0;
  logic [1:0]  force_spd = 2'b00;
  logic [1:0]  speed;
  logic        clk_ok;
  logic        gmii_1000m;
  logic        speed_chg;
  logic        meas_valid;
  logic [11:0] meas_cnt;

  real rx_half = 4.0;
  bit  rx_run = 1'b1;
  int  cyc = 0;
  int  base = 0;
  int  total = 0;
  int  bad = 0;
  int  diff;

  meas_exp_t meas_q[$];
  chg_exp_t  chg_q[$];
  meas_exp_t me;
  chg_exp_t  ce;

  gmii_speed_detect dut (
    .CLK200M    (clk),
    .SYS_RST    (rst),
    .GMII_RX_CLK(rx_clk),
    .FORCE_EN   (force_en),
    .FORCE_SPEED(force_spd),
    .SPEED      (speed),
    .CLK_OK     (clk_ok),
    .GMII_1000M (gmii_1000m),
    .SPEED_CHG  (speed_chg),
    .MEAS_VALID (meas_valid),
    .MEAS_CNT   (meas_cnt)
  );

  always #2.5 clk = ~clk;

  initial begin
    forever begin
      if (rx_run) #(rx_half) rx_clk = ~rx_clk;
      else #1;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every DUT event must match the head of its queue, cycle-exact.
  always @(negedge clk) begin
    if (meas_valid) begin
      total++;
      if (meas_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL meas_unexpected: got cnt=%0d at cyc=%0d, want no window result", meas_cnt, cyc - base);
      end else begin
        me = meas_q.pop_front();
        diff = int'(meas_cnt) - me.nom;
        if (cyc != me.exp_cyc || diff > me.tol || diff < -me.tol) begin
          bad++;
          $display("[TB] FAIL meas_cnt: got %0d at cyc=%0d, want %0d+-%0d at cyc=%0d",
                   meas_cnt, cyc - base, me.nom, me.tol, me.exp_cyc - base);
        end
      end
    end
    if (speed_chg) begin
      total++;
      if (chg_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL chg_unexpected: got speed=%b ok=%b gig=%b at cyc=%0d, want no change",
                 speed, clk_ok, gmii_1000m, cyc - base);
      end else begin
        ce = chg_q.pop_front();
        if (cyc != ce.exp_cyc || speed != ce.spd || clk_ok != ce.ok || gmii_1000m != ce.gig) begin
          bad++;
          $display("[TB] FAIL speed_chg: got speed=%b ok=%b gig=%b at cyc=%0d, want speed=%b ok=%b gig=%b at cyc=%0d",
                   speed, clk_ok, gmii_1000m, cyc - base, ce.spd, ce.ok, ce.gig, ce.exp_cyc - base);
        end
      end
    end
  end

  function automatic int nom_of(input int mode);
    case (mode)
      0: return 1250;
      1: return 250;
      2: return 25;
      default: return 0;
    endcase
  endfunction

  task automatic set_rate(input int mode);
    case (mode)
      0: begin rx_half = 4.0;   rx_run = 1'b1; end
      1: begin rx_half = 20.0;  rx_run = 1'b1; end
      2: begin rx_half = 200.0; rx_run = 1'b1; end
      default: rx_run = 1'b0;
    endcase
  endtask

  task automatic goto(input int rel);
    while (cyc < base + rel) @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    base = cyc;
  endtask

  // Sets the RX rate for window 'win' and queues its expected count.
  task automatic applyStimulus(input int win, input int mode, input int tol);
    goto(WIN * (win - 1) + 2);
    set_rate(mode);
    if (win >= 2) meas_q.push_back('{base + WIN * win, nom_of(mode), tol});
  endtask

  task automatic push_commit(input int win, input logic [1:0] spd, input logic ok, input logic gig);
    chg_q.push_back('{base + WIN * win + 1, spd, ok, gig});
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_speed"}, 16'(speed), 16'd0);
    checkOutput({tag, "_clk_ok"}, 16'(clk_ok), 16'd0);
    checkOutput({tag, "_gmii_1000m"}, 16'(gmii_1000m), 16'd0);
    checkOutput({tag, "_speed_chg"}, 16'(speed_chg), 16'd0);
    checkOutput({tag, "_meas_valid"}, 16'(meas_valid), 16'd0);
    checkOutput({tag, "_meas_cnt"}, 16'(meas_cnt), 16'd0);
  endtask

  initial begin
    set_rate(0);
    repeat (5) @(negedge clk);
    check_all_zero("reset");
    release_reset();

    // 125 MHz from reset: window 1 discarded, commit after window 4.
    for (int w = 1; w <= 4; w++) applyStimulus(w, 0, 2);
    push_commit(4, 2'b10, 1'b1, 1'b1);

    // 25 MHz.
    for (int w = 5; w <= 7; w++) applyStimulus(w, 1, (w == 5) ? 4 : 2);
    push_commit(7, 2'b01, 1'b1, 1'b0);

    // 2.5 MHz.
    for (int w = 8; w <= 10; w++) applyStimulus(w, 2, (w == 8) ? 4 : 2);
    push_commit(10, 2'b00, 1'b1, 1'b0);

    // Clock stopped: CLK_OK drops, SPEED held.
    for (int w = 11; w <= 13; w++) applyStimulus(w, 3, (w == 11) ? 2 : 0);
    push_commit(13, 2'b00, 1'b0, 1'b0);

    // Restart at 2.5 MHz.
    for (int w = 14; w <= 16; w++) applyStimulus(w, 2, (w == 14) ? 4 : 2);
    push_commit(16, 2'b00, 1'b1, 1'b0);

    // Alternating 125/25 never reaches agreement.
    for (int w = 17; w <= 22; w++) applyStimulus(w, (w % 2 == 1) ? 0 : 1, 4);
    applyStimulus(23, 1, 2);
    applyStimulus(24, 1, 2);
    push_commit(24, 2'b01, 1'b1, 1'b0);

    // Force 1000M while the link is at 25 MHz, then release mid-window 27.
    applyStimulus(25, 1, 2);
    goto(WIN * 24 + 500);
    chg_q.push_back('{cyc + 1, 2'b10, 1'b1, 1'b1});
    force_spd = 2'b10;
    force_en = 1'b1;
    applyStimulus(26, 1, 2);
    applyStimulus(27, 1, 2);
    goto(WIN * 26 + 500);
    force_en = 1'b0;
    push_commit(29, 2'b01, 1'b1, 1'b0);
    applyStimulus(28, 1, 2);
    applyStimulus(29, 1, 2);

    // Reset mid-window at 125 MHz; RX counter wraps during the re-run.
    goto(WIN * 29 + 2);
    set_rate(0);
    goto(WIN * 29 + 1000);
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    repeat (3) @(negedge clk);
    release_reset();
    for (int w = 1; w <= 4; w++) applyStimulus(w, 0, 2);
    push_commit(4, 2'b10, 1'b1, 1'b1);
    goto(WIN * 4 + 10);

    checkOutput("final_speed", 16'(speed), 16'd2);
    checkOutput("final_gmii_1000m", 16'(gmii_1000m), 16'd1);
    checkOutput("meas_q_drained", 16'(meas_q.size()), 16'd0);
    checkOutput("chg_q_drained", 16'(chg_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
